jtdd_gfx_rom_arb: RTL and testbench

Arbiter that shares one graphics ROM read port (SDRAM slot) between the three video fetchers: character layer, scroll layer and object layer. Each fetcher presents a region-relative address and a request. The arbiter grants one fetcher at a time, translates the address into the flat ROM map, runs the rom_cs/rom_ok handshake, and returns the data with a per-requester ok flag. It sits between the layer blocks and the SDRAM controller.

---
 rtl/jtdd_pkg.sv | 23 ++
 rtl/jtdd_gfx_rom_arb_if.sv | 12 +
 rtl/jtdd_rom_slot.sv | 47 ++++
 rtl/jtdd_gfx_rom_arb.sv | 131 +++++++++++++
 tb/tb_jtdd_gfx_rom_arb.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtdd_pkg.sv
// Shared types and default memory map for the graphics ROM arbiter.
package jtdd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Grant index; also the bit position of each requester in the
  // pending/load/fill vectors.
  typedef enum logic [1:0] {
    GNT_CHAR = 2'd0,
    GNT_SCR  = 2'd1,
    GNT_OBJ  = 2'd2
  } gnt_e;

  localparam int          DEF_ROM_AW     = 22;
  localparam logic [21:0] DEF_CHAR_BASE  = 22'h0;
  localparam logic [21:0] DEF_SCR_BASE   = 22'h08000;
  localparam logic [21:0] DEF_OBJ_BASE   = 22'h28000;
  localparam int          DEF_OBJ_STARVE = 4;

endpackage

// File: rtl/jtdd_gfx_rom_arb_if.sv
// ROM read port between the arbiter (master) and the SDRAM slot (slave).
interface jtdd_gfx_rom_arb_if #(
  parameter int ROM_AW = 22
);
  logic              cs;
  logic [ROM_AW-1:0] addr;
  logic [7:0]        data;
  logic              ok;

  modport master (output cs, addr, input data, ok);
  modport slave  (input cs, addr, output data, ok);
endinterface

// File: rtl/jtdd_rom_slot.sv
// One requester's last-fetch register with hit detection and a registered
// ok flag. The address is captured at grant time so a requester that moves
// its address mid-transfer ends up with the data for the granted address.
module jtdd_rom_slot #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          ld,         // granted: latch address, invalidate
  input  logic          fill,       // rom_ok for this requester
  input  logic [7:0]    fill_data,
  output logic          pending,
  output logic [7:0]    data,
  output logic          ok
);

  logic          valid;
  logic [AW-1:0] last_addr;
  logic          match;

  assign match   = valid && (addr == last_addr);
  assign pending = cs && !match;

  // Last-fetch register and the registered ok flag.
  always_ff @(posedge clk) begin
    // NOTE: data is a visible output from reset, so the whole last-fetch
    // register is reset, not just the valid bit.
    if (!rst_n) begin
      valid     <= 1'b0;
      last_addr <= '0;
      data      <= '0;
      ok        <= 1'b0;
    end else begin
      if (ld) begin
        last_addr <= addr;
        valid     <= 1'b0;
      end else if (fill) begin
        data  <= fill_data;
        valid <= 1'b1;
      end
      ok <= match;
    end
  end

endmodule

// File: rtl/jtdd_gfx_rom_arb.sv
// Shares one graphics ROM read port between the char, scroll and object
// fetchers. Fixed priority char > scroll > obj, with a starvation counter
// that forces an object grant after OBJ_STARVE consecutive other grants.
module jtdd_gfx_rom_arb
  import jtdd_pkg::*;
#(
  parameter int                CHAR_AW    = 15,
  parameter int                SCR_AW     = 17,
  parameter int                OBJ_AW     = 18,
  parameter int                ROM_AW     = DEF_ROM_AW,
  parameter logic [ROM_AW-1:0] CHAR_BASE  = DEF_CHAR_BASE,
  parameter logic [ROM_AW-1:0] SCR_BASE   = DEF_SCR_BASE,
  parameter logic [ROM_AW-1:0] OBJ_BASE   = DEF_OBJ_BASE,
  parameter int                OBJ_STARVE = DEF_OBJ_STARVE
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               char_cs,
  input  logic [CHAR_AW-1:0] char_addr,
  output logic [7:0]         char_data,
  output logic               char_ok,

  input  logic               scr_cs,
  input  logic [SCR_AW-1:0]  scr_addr,
  output logic [7:0]         scr_data,
  output logic               scr_ok,

  input  logic               obj_cs,
  input  logic [OBJ_AW-1:0]  obj_addr,
  output logic [7:0]         obj_data,
  output logic               obj_ok,

  jtdd_gfx_rom_arb_if.master rom
);

  localparam int SW = $clog2(OBJ_STARVE + 1);

  state_e            state, next_state;
  gnt_e              gnt, sel;
  logic [2:0]        pend, ld, fill;
  logic              grant;
  logic              obj_first;
  logic [SW-1:0]     starve;
  logic [ROM_AW-1:0] sel_addr;

  jtdd_rom_slot #(.AW(CHAR_AW)) u_char (
    .clk, .rst_n, .cs(char_cs), .addr(char_addr),
    .ld(ld[GNT_CHAR]), .fill(fill[GNT_CHAR]), .fill_data(rom.data),
    .pending(pend[GNT_CHAR]), .data(char_data), .ok(char_ok)
  );

  jtdd_rom_slot #(.AW(SCR_AW)) u_scr (
    .clk, .rst_n, .cs(scr_cs), .addr(scr_addr),
    .ld(ld[GNT_SCR]), .fill(fill[GNT_SCR]), .fill_data(rom.data),
    .pending(pend[GNT_SCR]), .data(scr_data), .ok(scr_ok)
  );

  jtdd_rom_slot #(.AW(OBJ_AW)) u_obj (
    .clk, .rst_n, .cs(obj_cs), .addr(obj_addr),
    .ld(ld[GNT_OBJ]), .fill(fill[GNT_OBJ]), .fill_data(rom.data),
    .pending(pend[GNT_OBJ]), .data(obj_data), .ok(obj_ok)
  );

  // Priority pick among pending requesters and its flat ROM address.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the if-chain leaves it unassigned (latch).
    sel       = GNT_CHAR;
    sel_addr  = CHAR_BASE + ROM_AW'(char_addr);
    obj_first = pend[GNT_OBJ] && (starve == SW'(OBJ_STARVE));
    if (obj_first) begin
      sel      = GNT_OBJ;
      sel_addr = OBJ_BASE + ROM_AW'(obj_addr);
    end else if (pend[GNT_CHAR]) begin
      sel      = GNT_CHAR;
      sel_addr = CHAR_BASE + ROM_AW'(char_addr);
    end else if (pend[GNT_SCR]) begin
      sel      = GNT_SCR;
      sel_addr = SCR_BASE + ROM_AW'(scr_addr);
    end else if (pend[GNT_OBJ]) begin
      sel      = GNT_OBJ;
      sel_addr = OBJ_BASE + ROM_AW'(obj_addr);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|pend)  next_state = WAIT;
      WAIT:    if (rom.ok) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: request strobe, per-slot load on grant, fill on rom_ok.
  always_comb begin
    rom.cs = (state == WAIT);
    grant  = (state == IDLE) && (|pend);
    ld     = grant ? (3'b001 << sel) : 3'b000;
    fill   = ((state == WAIT) && rom.ok) ? (3'b001 << gnt) : 3'b000;
  end

  // Granted index, ROM address and the object starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt      <= GNT_CHAR;
      rom.addr <= '0;
      starve   <= '0;
    end else begin
      if (grant) begin
        gnt      <= sel;
        rom.addr <= sel_addr;
      end
      if (!pend[GNT_OBJ] || (grant && sel == GNT_OBJ))
        starve <= '0;
      else if (grant && starve != SW'(OBJ_STARVE))
        starve <= starve + SW'(1);
    end
  end

endmodule

// File: tb/tb_jtdd_gfx_rom_arb.sv
// Self-checking bench for jtdd_gfx_rom_arb: directed scenarios followed by a
// randomized phase, all compared each cycle against a transaction-level model.
module tb_jtdd_gfx_rom_arb;

  localparam int OBJ_STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cs;
  logic [17:0] addr [3];
  logic [7:0]  data_o [3];
  logic        ok_o [3];

  always #5 clk = ~clk;

  jtdd_gfx_rom_arb_if #(.ROM_AW(22)) rom ();

  jtdd_gfx_rom_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_cs   (cs[0]),
    .char_addr (addr[0][14:0]),
    .char_data (data_o[0]),
    .char_ok   (ok_o[0]),
    .scr_cs    (cs[1]),
    .scr_addr  (addr[1][16:0]),
    .scr_data  (data_o[1]),
    .scr_ok    (ok_o[1]),
    .obj_cs    (cs[2]),
    .obj_addr  (addr[2]),
    .obj_data  (data_o[2]),
    .obj_ok    (ok_o[2]),
    .rom       (rom)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what each requester last fetched, the outstanding
  // transfer, and the run of non-object grants while obj waits.
  bit          m_valid [3];
  logic [17:0] m_laddr [3];
  logic [7:0]  m_data  [3];
  bit          m_ok    [3];
  bit          m_busy;
  int          m_gnt;
  logic [21:0] m_rom_addr;
  int          m_streak;
  int          gnt_log [$];

  // ROM responder controls.
  bit          manual;
  bit          fixed_en;
  logic [7:0]  fixed_data;
  int          wait_cnt, ok_delay, dmin, dmax;

  function automatic logic [21:0] base_of(int i);
    case (i)
      0:       return 22'h000000;
      1:       return 22'h008000;
      default: return 22'h028000;
    endcase
  endfunction

  function automatic logic [17:0] mask_of(int i);
    case (i)
      0:       return 18'h07FFF;
      1:       return 18'h1FFFF;
      default: return 18'h3FFFF;
    endcase
  endfunction

  function automatic logic [17:0] new_addr(int i, logic [17:0] old);
    logic [17:0] a;
    a = 18'($urandom) & mask_of(i);
    if (a == old) a = (a ^ 18'h1) & mask_of(i);
    return a;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the arbitration rules to the values present at this edge.
  task automatic model_edge();
    bit match [3];
    bit pend  [3];
    int win;
    for (int i = 0; i < 3; i++) begin
      match[i] = m_valid[i] && (addr[i] == m_laddr[i]);
      pend[i]  = cs[i] && !match[i];
    end
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 0; m_laddr[i] = '0; m_data[i] = '0; m_ok[i] = 0;
      end
      m_busy = 0; m_rom_addr = '0; m_streak = 0;
      return;
    end
    for (int i = 0; i < 3; i++) m_ok[i] = match[i];
    win = -1;
    if (m_busy) begin
      if (rom.ok) begin
        m_data[m_gnt]  = rom.data;
        m_valid[m_gnt] = 1;
        m_busy         = 0;
      end
    end else begin
      if (pend[2] && m_streak == OBJ_STARVE) win = 2;
      else
        for (int i = 0; i < 3; i++)
          if (pend[i] && win < 0) win = i;
      if (win >= 0) begin
        m_busy         = 1;
        m_gnt          = win;
        m_rom_addr     = base_of(win) + 22'(addr[win]);
        m_valid[win]   = 0;
        m_laddr[win]   = addr[win];
        gnt_log.push_back(win);
      end
    end
    if (!pend[2] || win == 2) m_streak = 0;
    else if (win >= 0 && m_streak < OBJ_STARVE) m_streak++;
  endtask

  task automatic check_all();
    check("rom_cs", 32'(rom.cs), 32'(m_busy));
    check("rom_addr", 32'(rom.addr), 32'(m_rom_addr));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ok%0d", i), 32'(ok_o[i]), 32'(m_ok[i]));
      check($sformatf("data%0d", i), 32'(data_o[i]), 32'(m_data[i]));
    end
  endtask

  // SDRAM stand-in: answers an outstanding request after ok_delay cycles.
  task automatic respond();
    if (manual) return;
    if (m_busy) begin
      if (wait_cnt >= ok_delay) begin
        rom.ok   = 1'b1;
        rom.data = fixed_en ? fixed_data : 8'($urandom);
        wait_cnt = 0;
        ok_delay = $urandom_range(dmax, dmin);
      end else begin
        rom.ok = 1'b0;
        wait_cnt++;
      end
    end else begin
      rom.ok   = 1'b0;
      wait_cnt = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    respond();
  endtask

  function automatic int log_code();
    int c = 0;
    foreach (gnt_log[k]) c = c * 4 + gnt_log[k];
    return c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    cs = '0;
    for (int i = 0; i < 3; i++) addr[i] = '0;
    rom.ok = 1'b0; rom.data = '0;
    manual = 0; fixed_en = 0; fixed_data = '0;
    wait_cnt = 0; ok_delay = 0; dmin = 0; dmax = 0;
    m_busy = 0; m_gnt = 0; m_rom_addr = '0; m_streak = 0;
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 0; m_laddr[i] = '0; m_data[i] = '0; m_ok[i] = 0;
    end

    // Reset state.
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Single char miss with zero-wait ROM.
    fixed_en = 1; fixed_data = 8'hA5;
    addr[0] = 18'h0123; cs = 3'b001;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      step(); lat++;
      if (ok_o[0] === 1'b1) break;
    end
    check("char_miss_latency", 32'(lat), 32'd3);
    check("char_miss_rom_addr", 32'(rom.addr), 32'h000123);
    check("char_miss_data", 32'(data_o[0]), 32'hA5);

    // Cache hit: same address stays served with no ROM traffic.
    repeat (4) step();
    check("hit_ok", 32'(ok_o[0]), 32'd1);
    check("hit_rom_cs", 32'(rom.cs), 32'd0);

    // Simultaneous misses resolve char, scroll, obj.
    fixed_en = 0; dmin = 0; dmax = 2;
    addr[0] = new_addr(0, addr[0]);
    addr[1] = new_addr(1, addr[1]);
    addr[2] = new_addr(2, addr[2]);
    gnt_log.delete();
    cs = 3'b111;
    for (int k = 0; k < 40; k++) begin
      step();
      if (gnt_log.size() >= 3 && !m_busy) break;
    end
    check("simul_grants", 32'(gnt_log.size()), 32'd3);
    check("simul_order", 32'(log_code()), 32'd6);

    // Starvation: char keeps missing, obj must win after 4 other grants.
    gnt_log.delete();
    addr[0] = new_addr(0, addr[0]);
    addr[1] = new_addr(1, addr[1]);
    addr[2] = new_addr(2, addr[2]);
    for (int k = 0; k < 80; k++) begin
      step();
      for (int i = 0; i < 2; i++)
        if (m_valid[i] && addr[i] == m_laddr[i]) addr[i] = new_addr(i, addr[i]);
      if (2 inside {gnt_log}) break;
    end
    n = 0;
    foreach (gnt_log[k]) begin
      if (gnt_log[k] == 2) break;
      n++;
    end
    check("starve_nonobj_grants", 32'(n), 32'(OBJ_STARVE));
    cs = 3'b000;
    repeat (6) step();

    // Scroll address moves while its transfer is in flight.
    dmin = 3; dmax = 3; ok_delay = 3;
    addr[1] = new_addr(1, addr[1]);
    gnt_log.delete();
    cs = 3'b010;
    for (int k = 0; k < 10; k++) begin
      step();
      if (m_busy) break;
    end
    addr[1] = new_addr(1, addr[1]);
    for (int k = 0; k < 40; k++) begin
      step();
      if (ok_o[1] === 1'b1) break;
    end
    check("chg_grants", 32'(gnt_log.size()), 32'd2);
    check("chg_ok", 32'(ok_o[1]), 32'd1);
    check("chg_rom_addr", 32'(rom.addr), 32'(22'h008000 + 22'(addr[1])));
    cs = 3'b000;
    repeat (3) step();

    // Reset while waiting on the ROM; late rom_ok must be ignored.
    dmin = 10; dmax = 10; ok_delay = 10;
    addr[0] = new_addr(0, addr[0]);
    cs = 3'b001;
    for (int k = 0; k < 10; k++) begin
      step();
      if (m_busy) break;
    end
    check("rst_pre_rom_cs", 32'(rom.cs), 32'd1);
    manual = 1; rom.ok = 1'b1; rom.data = 8'h77;
    rst_n = 1'b0; cs = 3'b000;
    step();
    check("rst_rom_cs", 32'(rom.cs), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_late_ok_rom_cs", 32'(rom.cs), 32'd0);
    check("rst_late_ok_data", 32'(data_o[0]), 32'd0);
    rom.ok = 1'b0; manual = 0; wait_cnt = 0;
    dmin = 0; dmax = 0; ok_delay = 0;
    fixed_en = 1; fixed_data = 8'h3C;
    cs = 3'b001;
    for (int k = 0; k < 10; k++) begin
      step();
      if (ok_o[0] === 1'b1) break;
    end
    check("rst_serve_ok", 32'(ok_o[0]), 32'd1);
    check("rst_serve_data", 32'(data_o[0]), 32'h3C);

    // Randomized traffic from a small address pool, including all-ones.
    fixed_en = 0; dmin = 0; dmax = 3;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(3, 0) == 0) cs[i] = 1'($urandom);
        if ($urandom_range(5, 0) == 0)
          case ($urandom_range(3, 0))
            0:       addr[i] = '0;
            1:       addr[i] = mask_of(i);
            2:       addr[i] = 18'h1;
            default: addr[i] = 18'($urandom) & mask_of(i);
          endcase
      end
      step();
    end
    cs = 3'b000;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
